// File: rtl/kamacore_pkg.sv
// Shared types and constants for the kamacore hazard unit.
package kamacore_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } hazard_state_t;

  localparam int REG_W_DEFAULT = 4;
  localparam logic [REG_W_DEFAULT-1:0] REG_ZERO = 4'd0;

endpackage

// File: rtl/kamacore_hazard_unit_if.sv
// Pipeline-to-hazard-unit bundle: ID/EX hazard sources in, pipeline controls and statistics out.
interface kamacore_hazard_unit_if
  import kamacore_pkg::*;
#(
  parameter int REG_W  = REG_W_DEFAULT,
  parameter int STAT_W = 16
);
  logic              ID_valid;
  logic [REG_W-1:0]  ID_register_a;
  logic              ID_uses_a;
  logic [REG_W-1:0]  ID_register_b;
  logic              ID_uses_b;
  logic [REG_W-1:0]  EX_destination_register;
  logic              EX_control_write_register;
  logic              EX_control_mem_read;
  logic              EX_multicycle_start;
  logic              EX_branch_taken;
  logic              stall_IF;
  logic              stall_ID;
  logic              hold_EX;
  logic              bubble_EX;
  logic              bubble_MEM;
  logic              flush_ID;
  logic              mc_done;
  logic [STAT_W-1:0] stat_stall_cycles;
  logic [STAT_W-1:0] stat_flushes;

  modport master (
    output ID_valid, ID_register_a, ID_uses_a, ID_register_b, ID_uses_b,
    output EX_destination_register, EX_control_write_register, EX_control_mem_read,
    output EX_multicycle_start, EX_branch_taken,
    input  stall_IF, stall_ID, hold_EX, bubble_EX, bubble_MEM, flush_ID, mc_done,
    input  stat_stall_cycles, stat_flushes
  );

  modport slave (
    input  ID_valid, ID_register_a, ID_uses_a, ID_register_b, ID_uses_b,
    input  EX_destination_register, EX_control_write_register, EX_control_mem_read,
    input  EX_multicycle_start, EX_branch_taken,
    output stall_IF, stall_ID, hold_EX, bubble_EX, bubble_MEM, flush_ID, mc_done,
    output stat_stall_cycles, stat_flushes
  );
endinterface

// File: rtl/kamacore_hazard_unit_chk.sv
// Simulation checks on the hazard unit inputs.
module kamacore_hazard_unit_chk (
  input logic clk,
  input logic reset,
  input logic start,
  input logic branch
);

  // one instruction cannot both start a multi-cycle op and resolve a taken branch
  a_start_with_branch: assert property (@(posedge clk) disable iff (!reset) !(start && branch));

endmodule

// File: rtl/kamacore_multicycle_timer.sv
// Loadable down-counter; zero reports whether the value held after this cycle's load/decrement is zero.
module kamacore_multicycle_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;

  // next count: load wins over decrement, decrement stops at zero
  always_comb begin
    count_next_s = count_r;
    if (load) begin
      count_next_s = load_value;
    end else if (dec && (count_r != {CNT_W{1'b0}})) begin
      count_next_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_next_s = count_r;
    end
  end

  // count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_next_s;
    end
  end

  assign zero = (count_next_s == {CNT_W{1'b0}});

endmodule

// File: rtl/kamacore_hazard_unit.sv
// Load-use / multi-cycle / taken-branch hazard control. Optional statistics: KAMACORE_HAZARD_STATS_EN.
module kamacore_hazard_unit
  import kamacore_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int REG_W      = REG_W_DEFAULT,
  parameter int STAT_W     = 16
) (
  input logic                   clk,
  input logic                   reset,
  kamacore_hazard_unit_if.slave hz
);

  localparam int CNT_W = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;

  hazard_state_t state_r;
  hazard_state_t state_next_s;
  logic          lu_s;
  logic          timer_load_s;
  logic          timer_dec_s;
  logic          timer_zero_s;
  logic          stall_if_s;
  logic          stall_id_s;
  logic          hold_ex_s;
  logic          bubble_ex_s;
  logic          bubble_mem_s;
  logic          flush_id_s;
  logic          mc_done_s;

  assign lu_s = hz.ID_valid & hz.EX_control_mem_read & hz.EX_control_write_register
              & (hz.EX_destination_register != REG_W'(REG_ZERO))
              & ((hz.ID_uses_a & (hz.ID_register_a == hz.EX_destination_register))
               | (hz.ID_uses_b & (hz.ID_register_b == hz.EX_destination_register)));

  // kept outside the FSM process so the timer's zero flag does not form a loop through it
  assign timer_load_s = (state_r == IDLE) & hz.EX_multicycle_start;
  assign timer_dec_s  = (state_r == BUSY);

  kamacore_multicycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load_s),
    .load_value (CNT_W'(MC_LATENCY - 2)),
    .dec        (timer_dec_s),
    .zero       (timer_zero_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next state and prioritised control outputs
  always_comb begin
    state_next_s = state_r;
    stall_if_s   = 1'b0;
    stall_id_s   = 1'b0;
    hold_ex_s    = 1'b0;
    bubble_ex_s  = 1'b0;
    bubble_mem_s = 1'b0;
    flush_id_s   = 1'b0;
    mc_done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        // zero here means MC_LATENCY==2: no BUSY cycles at all
        if (hz.EX_multicycle_start) begin
          state_next_s = timer_zero_s ? DONE : BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        state_next_s = timer_zero_s ? DONE : BUSY;
      end
      DONE: begin
        mc_done_s    = 1'b1;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    // EX is frozen while BUSY, so branch and load-use cannot apply there
    if (state_r == BUSY) begin
      stall_if_s   = 1'b1;
      stall_id_s   = 1'b1;
      hold_ex_s    = 1'b1;
      bubble_mem_s = 1'b1;
    end else if (hz.EX_branch_taken) begin
      flush_id_s   = 1'b1;
      bubble_ex_s  = 1'b1;
    end else if (lu_s) begin
      stall_if_s   = 1'b1;
      stall_id_s   = 1'b1;
      bubble_ex_s  = 1'b1;
    end else begin
      stall_if_s   = 1'b0;
    end
    if (!reset) begin
      stall_if_s   = 1'b0;
      stall_id_s   = 1'b0;
      hold_ex_s    = 1'b0;
      bubble_ex_s  = 1'b0;
      bubble_mem_s = 1'b0;
      flush_id_s   = 1'b0;
      mc_done_s    = 1'b0;
    end else begin
      mc_done_s    = mc_done_s;
    end
  end

  assign hz.stall_IF   = stall_if_s;
  assign hz.stall_ID   = stall_id_s;
  assign hz.hold_EX    = hold_ex_s;
  assign hz.bubble_EX  = bubble_ex_s;
  assign hz.bubble_MEM = bubble_mem_s;
  assign hz.flush_ID   = flush_id_s;
  assign hz.mc_done    = mc_done_s;

`ifdef KAMACORE_HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_r;
  logic [STAT_W-1:0] flush_cnt_r;

  // saturating statistics counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= {STAT_W{1'b0}};
      flush_cnt_r <= {STAT_W{1'b0}};
    end else begin
      if (stall_if_s && (stall_cnt_r != {STAT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + STAT_W'(1);
      end
      if (flush_id_s && (flush_cnt_r != {STAT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + STAT_W'(1);
      end
    end
  end

  assign hz.stat_stall_cycles = stall_cnt_r;
  assign hz.stat_flushes      = flush_cnt_r;
`else
  assign hz.stat_stall_cycles = {STAT_W{1'b0}};
  assign hz.stat_flushes      = {STAT_W{1'b0}};
`endif

  kamacore_hazard_unit_chk u_chk (
    .clk    (clk),
    .reset  (reset),
    .start  (hz.EX_multicycle_start),
    .branch (hz.EX_branch_taken)
  );

endmodule

// File: tb/tb_kamacore_hazard_unit.sv
// Directed bench for kamacore_hazard_unit: combinational vector table plus multi-cycle/reset/statistics sequences.
module tb_kamacore_hazard_unit;

  // packed output order: {stall_IF, stall_ID, hold_EX, bubble_EX, bubble_MEM, flush_ID, mc_done}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1101000;
  localparam logic [6:0] O_BR   = 7'b0001010;
  localparam logic [6:0] O_BUSY = 7'b1110100;
  localparam logic [6:0] O_DONE = 7'b0000001;

`ifdef KAMACORE_HAZARD_STATS_EN
  localparam logic [15:0] EXP_STALLS  = 16'd5;
  localparam logic [15:0] EXP_FLUSHES = 16'd1;
`else
  localparam logic [15:0] EXP_STALLS  = 16'd0;
  localparam logic [15:0] EXP_FLUSHES = 16'd0;
`endif

  typedef struct {
    string      name;
    logic       valid;
    logic [3:0] ra;
    logic       ua;
    logic [3:0] rb;
    logic       ub;
    logic [3:0] dest;
    logic       wr;
    logic       mr;
    logic       br;
    logic [6:0] exp;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  vec_t vecs[11];

  kamacore_hazard_unit_if #(.REG_W(4), .STAT_W(16)) hz ();

  kamacore_hazard_unit #(.MC_LATENCY(4), .REG_W(4), .STAT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {hz.stall_IF, hz.stall_ID, hz.hold_EX, hz.bubble_EX, hz.bubble_MEM, hz.flush_ID, hz.mc_done};
  endfunction

  function automatic vec_t mk(string name, logic valid, logic [3:0] ra, logic ua, logic [3:0] rb,
                              logic ub, logic [3:0] dest, logic wr, logic mr, logic br, logic [6:0] exp);
    vec_t v;
    v.name = name; v.valid = valid; v.ra = ra; v.ua = ua; v.rb = rb; v.ub = ub;
    v.dest = dest; v.wr = wr; v.mr = mr; v.br = br; v.exp = exp;
    return v;
  endfunction

  task automatic check7(string name, logic [6:0] got, logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs %b, expected %b", name, got, exp);
    end
  endtask

  task automatic check16(string name, logic [15:0] got, logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: value %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    hz.ID_valid = 1'b0; hz.ID_register_a = 4'd0; hz.ID_uses_a = 1'b0;
    hz.ID_register_b = 4'd0; hz.ID_uses_b = 1'b0; hz.EX_destination_register = 4'd0;
    hz.EX_control_write_register = 1'b0; hz.EX_control_mem_read = 1'b0;
    hz.EX_multicycle_start = 1'b0; hz.EX_branch_taken = 1'b0;
  endtask

  task automatic set_lu();
    hz.ID_valid = 1'b1; hz.ID_register_b = 4'd3; hz.ID_uses_b = 1'b1;
    hz.EX_destination_register = 4'd3; hz.EX_control_write_register = 1'b1;
    hz.EX_control_mem_read = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // start + 2 BUSY + DONE + IDLE; start is also held in BUSY and DONE to show it is ignored
  task automatic run_mc(string tag);
    clear_inputs(); hz.EX_multicycle_start = 1'b1;
    @(negedge clk); check7({tag, "_start"}, outs(), O_NONE);
    next_cycle(); set_lu(); hz.EX_multicycle_start = 1'b1;
    @(negedge clk); check7({tag, "_busy1"}, outs(), O_BUSY);
    next_cycle(); hz.EX_multicycle_start = 1'b0; hz.EX_branch_taken = 1'b1;
    @(negedge clk); check7({tag, "_busy2"}, outs(), O_BUSY);
    next_cycle(); clear_inputs(); hz.EX_multicycle_start = 1'b1;
    @(negedge clk); check7({tag, "_done"}, outs(), O_DONE);
    next_cycle(); clear_inputs();
    @(negedge clk); check7({tag, "_idle"}, outs(), O_NONE);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = mk("all_zero",      1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_NONE);
    vecs[1]  = mk("lu_port_b",     1'b1, 4'd1, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, O_LU);
    vecs[2]  = mk("lu_r0",         1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, O_NONE);
    vecs[3]  = mk("lu_a_unused",   1'b1, 4'd3, 1'b0, 4'd5, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, O_NONE);
    vecs[4]  = mk("lu_port_a",     1'b1, 4'd9, 1'b1, 4'd2, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0, O_LU);
    vecs[5]  = mk("id_invalid",    1'b0, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, O_NONE);
    vecs[6]  = mk("alu_no_load",   1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, O_NONE);
    vecs[7]  = mk("load_no_write", 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, O_NONE);
    vecs[8]  = mk("branch_over_lu",1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, O_BR);
    vecs[9]  = mk("branch_only",   1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, O_BR);
    vecs[10] = mk("src_mismatch",  1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, O_NONE);

    // reset state: outputs forced low even with a hazard on the inputs
    clear_inputs(); set_lu(); reset = 1'b0;
    #2;
    check7("reset_outputs", outs(), O_NONE);
    check16("reset_stat_stalls", hz.stat_stall_cycles, 16'd0);
    check16("reset_stat_flushes", hz.stat_flushes, 16'd0);
    @(negedge clk); reset = 1'b1; clear_inputs();
    next_cycle();

    for (int i = 0; i < 11; i++) begin
      hz.ID_valid = vecs[i].valid; hz.ID_register_a = vecs[i].ra; hz.ID_uses_a = vecs[i].ua;
      hz.ID_register_b = vecs[i].rb; hz.ID_uses_b = vecs[i].ub;
      hz.EX_destination_register = vecs[i].dest; hz.EX_control_write_register = vecs[i].wr;
      hz.EX_control_mem_read = vecs[i].mr; hz.EX_branch_taken = vecs[i].br;
      @(negedge clk); check7(vecs[i].name, outs(), vecs[i].exp);
      next_cycle();
    end

    // load-use lasts one cycle: the load moves to MEM and the hazard is gone
    clear_inputs(); set_lu();
    @(negedge clk); check7("lu_seq_stall", outs(), O_LU);
    next_cycle(); clear_inputs(); hz.ID_valid = 1'b1; hz.ID_register_b = 4'd3; hz.ID_uses_b = 1'b1;
    @(negedge clk); check7("lu_seq_release", outs(), O_NONE);
    next_cycle();

    run_mc("mc");

    // async reset in the second BUSY cycle
    next_cycle(); clear_inputs(); hz.EX_multicycle_start = 1'b1;
    next_cycle(); hz.EX_multicycle_start = 1'b0;
    @(negedge clk); check7("rst_busy1", outs(), O_BUSY);
    next_cycle();
    @(negedge clk); check7("rst_busy2", outs(), O_BUSY);
    #1; reset = 1'b0; set_lu(); hz.EX_branch_taken = 1'b1;
    #1; check7("rst_async_outputs", outs(), O_NONE);
    check16("rst_stat_stalls", hz.stat_stall_cycles, 16'd0);
    next_cycle();
    @(negedge clk); check7("rst_held", outs(), O_NONE);
    #1; reset = 1'b1; clear_inputs();
    next_cycle();
    @(negedge clk); check7("rst_idle", outs(), O_NONE);
    next_cycle();
    run_mc("mc_after_rst");

    // three load-use stalls on top of the two BUSY cycles above
    for (int i = 0; i < 3; i++) begin
      next_cycle(); clear_inputs(); set_lu();
      @(negedge clk); check7("lu_stat_stall", outs(), O_LU);
    end
    next_cycle(); clear_inputs();
    @(negedge clk); check16("stat_stall_cycles", hz.stat_stall_cycles, EXP_STALLS);
    check16("stat_flushes_before", hz.stat_flushes, 16'd0);

    next_cycle(); set_lu(); hz.EX_branch_taken = 1'b1;
    @(negedge clk); check7("branch_flush", outs(), O_BR);
    next_cycle(); clear_inputs();
    @(negedge clk); check16("stat_flushes_after", hz.stat_flushes, EXP_FLUSHES);
    check7("final_idle", outs(), O_NONE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
